control_unit: RTL and testbench



---
 rtl/control_unit.sv | 176 +++++++++++++++++
 tb/tb_control_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - main opcode decoder of the 16-bit RISC core
// Registered control bundle; unknown, reserved and NOP opcodes all decode to the all-zero bundle.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic [2:0] alu_op,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       jump,
  output logic       cmp,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_to_reg
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_ANDI = 4'b1001;
  localparam logic [3:0] OP_ORI  = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;

  logic [2:0] alu_op_d, alu_op_q;
  logic       reg_wr_d, reg_wr_q;
  logic       reg_dst_d, reg_dst_q;
  logic       alu_src_d, alu_src_q;
  logic       jump_d, jump_q;
  logic       cmp_d, cmp_q;
  logic       mem_rd_d, mem_rd_q;
  logic       mem_wr_d, mem_wr_q;
  logic       mem_to_reg_d, mem_to_reg_q;

  // Case items match exactly, so any X/Z opcode bit lands in the default (NOP) arm.
  always_comb begin
    alu_op_d     = ALU_ADD;
    reg_wr_d     = 1'b0;
    reg_dst_d    = 1'b0;
    alu_src_d    = 1'b0;
    jump_d       = 1'b0;
    cmp_d        = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_to_reg_d = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_op_d  = ALU_ADD;
        reg_wr_d  = 1'b1;
        reg_dst_d = 1'b1;
      end
      OP_SUB: begin
        alu_op_d  = ALU_SUB;
        reg_wr_d  = 1'b1;
        reg_dst_d = 1'b1;
      end
      OP_AND: begin
        alu_op_d  = ALU_AND;
        reg_wr_d  = 1'b1;
        reg_dst_d = 1'b1;
      end
      OP_OR: begin
        alu_op_d  = ALU_OR;
        reg_wr_d  = 1'b1;
        reg_dst_d = 1'b1;
      end
      OP_XOR: begin
        alu_op_d  = ALU_XOR;
        reg_wr_d  = 1'b1;
        reg_dst_d = 1'b1;
      end
      OP_SLL: begin
        alu_op_d  = ALU_SLL;
        reg_wr_d  = 1'b1;
        reg_dst_d = 1'b1;
      end
      OP_SRL: begin
        alu_op_d  = ALU_SRL;
        reg_wr_d  = 1'b1;
        reg_dst_d = 1'b1;
      end
      OP_ADDI: begin
        alu_op_d  = ALU_ADD;
        reg_wr_d  = 1'b1;
        alu_src_d = 1'b1;
      end
      OP_ANDI: begin
        alu_op_d  = ALU_AND;
        reg_wr_d  = 1'b1;
        alu_src_d = 1'b1;
      end
      OP_ORI: begin
        alu_op_d  = ALU_OR;
        reg_wr_d  = 1'b1;
        alu_src_d = 1'b1;
      end
      OP_LW: begin
        alu_op_d     = ALU_ADD;
        reg_wr_d     = 1'b1;
        alu_src_d    = 1'b1;
        mem_rd_d     = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      OP_SW: begin
        alu_op_d  = ALU_ADD;
        alu_src_d = 1'b1;
        mem_wr_d  = 1'b1;
      end
      OP_BEQ: begin
        alu_op_d = ALU_SUB;
        cmp_d    = 1'b1;
      end
      OP_JMP: begin
        jump_d = 1'b1;
      end
      OP_NOP: begin
        alu_op_d = ALU_ADD;
      end
      default: begin
        alu_op_d = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_q     <= 3'b000;
      reg_wr_q     <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      jump_q       <= 1'b0;
      cmp_q        <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      alu_op_q     <= alu_op_d;
      reg_wr_q     <= reg_wr_d;
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      jump_q       <= jump_d;
      cmp_q        <= cmp_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign reg_wr     = reg_wr_q;
  assign reg_dst    = reg_dst_q;
  assign alu_src    = alu_src_q;
  assign jump       = jump_q;
  assign cmp        = cmp_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
// Bundle order: {alu_op[2:0], reg_wr, reg_dst, alu_src, jump, cmp, mem_rd, mem_wr, mem_to_reg}.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [2:0] alu_op;
  logic       reg_wr, reg_dst, alu_src, jump, cmp, mem_rd, mem_wr, mem_to_reg;

  int checks;
  int failures;

  control_unit dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .alu_op    (alu_op),
    .reg_wr    (reg_wr),
    .reg_dst   (reg_dst),
    .alu_src   (alu_src),
    .jump      (jump),
    .cmp       (cmp),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_to_reg(mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] actual;
  assign actual = {alu_op, reg_wr, reg_dst, alu_src, jump, cmp, mem_rd, mem_wr, mem_to_reg};

  // Reference: R-type ops 1..7 map to ALU function (opcode-1); the rest come from the ISA table.
  function automatic logic [10:0] model(input logic [3:0] op, input logic r);
    logic [2:0] a;
    logic wr, dst, src, j, c, mrd, mwr, m2r;
    a = 3'd0; wr = 0; dst = 0; src = 0; j = 0; c = 0; mrd = 0; mwr = 0; m2r = 0;
    if (r || $isunknown(op)) return 11'd0;
    if (op >= 4'd1 && op <= 4'd7) begin
      a = 3'(op - 4'd1);
      wr = 1; dst = 1;
    end else if (op == 4'd8) begin
      wr = 1; src = 1;
    end else if (op == 4'd9) begin
      a = 3'd2; wr = 1; src = 1;
    end else if (op == 4'd10) begin
      a = 3'd3; wr = 1; src = 1;
    end else if (op == 4'd11) begin
      wr = 1; src = 1; mrd = 1; m2r = 1;
    end else if (op == 4'd12) begin
      src = 1; mwr = 1;
    end else if (op == 4'd13) begin
      a = 3'd1; c = 1;
    end else if (op == 4'd14) begin
      j = 1;
    end
    return {a, wr, dst, src, j, c, mrd, mwr, m2r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    opcode = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (actual !== 11'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d actual=%b expected=%b", i, actual, 11'd0);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (actual !== 11'b000_1_0_1_0_0_1_0_1) begin
      failures++;
      $display("FAIL reset_release_lw actual=%b expected=%b", actual, 11'b000_1_0_1_0_0_1_0_1);
    end
  endtask

  task automatic test_sweep();
    logic [10:0] held;
    for (int i = 0; i < 16; i++) begin
      opcode = 4'(i);
      tick();
      checks++;
      if (actual !== model(4'(i), 1'b0)) begin
        failures++;
        $display("FAIL sweep op=%0d actual=%b expected=%b", i, actual, model(4'(i), 1'b0));
      end
    end
    // Opcode change between edges must not reach the outputs.
    held = actual;
    opcode = 4'b0001;
    #2;
    checks++;
    if (actual !== held) begin
      failures++;
      $display("FAIL no_comb_path actual=%b expected=%b", actual, held);
    end
  endtask

  task automatic test_rtype();
    opcode = 4'b0010;
    tick();
    checks++;
    if (actual !== 11'b001_1_1_0_0_0_0_0_0) begin
      failures++;
      $display("FAIL rtype_sub actual=%b expected=%b", actual, 11'b001_1_1_0_0_0_0_0_0);
    end
  endtask

  task automatic test_mem_ctrl();
    opcode = 4'b1100;
    tick();
    checks++;
    if (actual !== 11'b000_0_0_1_0_0_0_1_0) begin
      failures++;
      $display("FAIL sw actual=%b expected=%b", actual, 11'b000_0_0_1_0_0_0_1_0);
    end
    opcode = 4'b1101;
    tick();
    checks++;
    if (actual !== 11'b001_0_0_0_0_1_0_0_0) begin
      failures++;
      $display("FAIL beq actual=%b expected=%b", actual, 11'b001_0_0_0_0_1_0_0_0);
    end
    opcode = 4'b1110;
    tick();
    checks++;
    if (actual !== 11'b000_0_0_0_1_0_0_0_0) begin
      failures++;
      $display("FAIL jmp actual=%b expected=%b", actual, 11'b000_0_0_0_1_0_0_0_0);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] add_b;
    add_b = 11'b000_1_1_0_0_0_0_0_0;
    opcode = 4'b0001;
    tick();
    checks++;
    if (actual !== add_b) begin
      failures++;
      $display("FAIL mid_before actual=%b expected=%b", actual, add_b);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (actual !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset actual=%b expected=%b", actual, 11'd0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (actual !== add_b) begin
      failures++;
      $display("FAIL mid_resume actual=%b expected=%b", actual, add_b);
    end
  endtask

  task automatic test_x();
    opcode = 4'b1011;
    tick();
    opcode = 4'bxxxx;
    tick();
    checks++;
    if (actual !== 11'd0) begin
      failures++;
      $display("FAIL x_opcode actual=%b expected=%b", actual, 11'd0);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [3:0] op;
    logic       r;
    logic [10:0] exp_b;
    for (int i = 0; i < 1000; i++) begin
      op = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 19) == 0);
      opcode = op;
      rst = r;
      exp_b = model(op, r);
      tick();
      checks++;
      if (actual !== exp_b) begin
        failures++;
        $display("FAIL rand_bundle i=%0d op=%b rst=%b actual=%b expected=%b", i, op, r, actual, exp_b);
      end
      checks++;
      if ((mem_rd && mem_wr) || (jump && cmp)) begin
        failures++;
        $display("FAIL inv_exclusive i=%0d actual=%b expected=no_overlap", i, actual);
      end
      checks++;
      if ((mem_to_reg && !(mem_rd && reg_wr)) || (reg_wr && (mem_wr || jump || cmp))) begin
        failures++;
        $display("FAIL inv_regwr i=%0d actual=%b expected=consistent", i, actual);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    opcode = 4'b0000;
    test_reset();
    test_sweep();
    test_rtype();
    test_mem_ctrl();
    test_reset_mid();
    test_x();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
